bbox_merge_sched: RTL and testbench

Frame-level sequencer for the bounding-box merge engine.
- Collects raw boxes from the labelling stage into a local box RAM and builds the 512-bit valid-flag vector.
- Starts the merge engine, serves its address-driven reads from the RAM, and forwards merged boxes downstream.
- Ends each frame with a status word.
- Sits between the connected-component labeller and the object-list output stage.

---
 rtl/bbox_pkg.sv | 19 +
 rtl/bbox_ram.sv | 18 +
 rtl/bbox_merge_sched.sv | 140 ++++++++++++++
 tb/tb_bbox_merge_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// bbox_pkg: shared sizes, box word layout, sequencer states and status bit positions
package bbox_pkg;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam logic [15:0] WDOG = 16'd40000;
  localparam int X_W = 7;
  localparam int Y_W = 6;
  localparam int BOX_W = 2 * X_W + 2 * Y_W;
  typedef struct packed {
    logic [X_W-1:0] x0;
    logic [X_W-1:0] xn;
    logic [Y_W-1:0] y0;
    logic [Y_W-1:0] yn;
  } box_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_MERGE, S_FIN} state_t;
  localparam int ST_OVF = 15;
  localparam int ST_WDOG = 14;
  localparam int ST_EMPTY = 13;
endpackage

// File: rtl/bbox_ram.sv
// bbox_ram: DEPTH x box_t simple dual-port RAM, one write port and one registered read port
module bbox_ram
  import bbox_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  box_t          wdata,
  input  logic [AW-1:0] raddr,
  output box_t          rdata
);
  box_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    rdata <= reset ? '0 : mem[raddr];
endmodule

// File: rtl/bbox_merge_sched.sv
// bbox_merge_sched: frame sequencer collecting raw boxes, driving the merge engine and reporting frame status
module bbox_merge_sched
  import bbox_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [X_W-1:0]   in_x0,
  input  logic [X_W-1:0]   in_xn,
  input  logic [Y_W-1:0]   in_y0,
  input  logic [Y_W-1:0]   in_yn,
  input  logic             in_frame_end,
  output logic             in_ready,
  output logic             eng_start,
  output logic [AW-1:0]    eng_size,
  output logic [DEPTH-1:0] eng_flags,
  input  logic [AW-1:0]    eng_addr,
  output logic [X_W-1:0]   eng_x0,
  output logic [X_W-1:0]   eng_xn,
  output logic [Y_W-1:0]   eng_y0,
  output logic [Y_W-1:0]   eng_yn,
  input  logic             eng_out_en,
  input  logic [X_W-1:0]   eng_out_x0,
  input  logic [X_W-1:0]   eng_out_xn,
  input  logic [Y_W-1:0]   eng_out_y0,
  input  logic [Y_W-1:0]   eng_out_yn,
  input  logic             eng_complete,
  output logic             out_valid,
  output logic [X_W-1:0]   out_x0,
  output logic [X_W-1:0]   out_xn,
  output logic [Y_W-1:0]   out_y0,
  output logic [Y_W-1:0]   out_yn,
  output logic             frame_done,
  output logic [15:0]      frame_status
);
  localparam logic [15:0] WDOG_LAST = WDOG - 16'd1;
  state_t state;
  logic [AW:0] cnt;
  logic [AW-1:0] merged_cnt;
  logic [15:0] wd;
  logic ovf, wdog, empty, we;
  box_t rd;
  assign in_ready = state == S_IDLE || state == S_LOAD;
  assign we = in_ready && in_valid && !cnt[AW];
  assign eng_size = cnt[AW] ? AW'(DEPTH - 1) : cnt[AW-1:0];
  assign eng_x0 = rd.x0;
  assign eng_xn = rd.xn;
  assign eng_y0 = rd.y0;
  assign eng_yn = rd.yn;
  always_comb begin
    frame_status = {7'b0, merged_cnt};
    frame_status[ST_OVF] = ovf;
    frame_status[ST_WDOG] = wdog;
    frame_status[ST_EMPTY] = empty;
  end
  bbox_ram u_ram (
    .clk(clk),
    .reset(reset),
    .we(we),
    .waddr(cnt[AW-1:0]),
    .wdata({in_x0, in_xn, in_y0, in_yn}),
    .raddr(eng_addr),
    .rdata(rd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      eng_flags <= '0;
      merged_cnt <= '0;
      wd <= '0;
      ovf <= 1'b0;
      wdog <= 1'b0;
      empty <= 1'b0;
      eng_start <= 1'b0;
      frame_done <= 1'b0;
      out_valid <= 1'b0;
      out_x0 <= '0;
      out_xn <= '0;
      out_y0 <= '0;
      out_yn <= '0;
    end else begin
      eng_start <= 1'b0;
      frame_done <= 1'b0;
      out_valid <= 1'b0;
      if (we) begin
        cnt <= cnt + (AW+1)'(1);
        eng_flags[cnt[AW-1:0]] <= 1'b1;
      end
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_valid) state <= S_LOAD;
          if (in_frame_end) begin
            if ((|cnt) || we) begin
              state <= S_START;
              eng_start <= 1'b1;
            end else begin
              state <= S_FIN;
              empty <= 1'b1;
              frame_done <= 1'b1;
            end
          end
        end
        S_START: begin
          state <= S_MERGE;
          wd <= '0;
        end
        S_MERGE: begin
          if (eng_out_en) begin
            out_valid <= 1'b1;
            out_x0 <= eng_out_x0;
            out_xn <= eng_out_xn;
            out_y0 <= eng_out_y0;
            out_yn <= eng_out_yn;
            merged_cnt <= merged_cnt + AW'(1);
          end
          if (eng_complete) begin
            state <= S_FIN;
            frame_done <= 1'b1;
          end else if (wd == WDOG_LAST) begin
            state <= S_FIN;
            wdog <= 1'b1;
            frame_done <= 1'b1;
          end else wd <= wd + 16'd1;
        end
        S_FIN: begin
          state <= S_IDLE;
          cnt <= '0;
          eng_flags <= '0;
          merged_cnt <= '0;
          ovf <= 1'b0;
          wdog <= 1'b0;
          empty <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      // a dropped input in FIN lands after the clear, so it is reported with the next frame
      if ((in_valid && in_ready && cnt[AW]) || (!in_ready && (in_valid || in_frame_end))) ovf <= 1'b1;
    end
endmodule

// File: tb/tb_bbox_merge_sched.sv
// tb_bbox_merge_sched: randomized scoreboard bench for bbox_merge_sched against a frame-level model
module tb_bbox_merge_sched;
  localparam int WDOG = 40000;
  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_frame_end, in_ready, eng_start, eng_out_en, eng_complete, out_valid, frame_done;
  logic [6:0] in_x0, in_xn, eng_x0, eng_xn, eng_out_x0, eng_out_xn, out_x0, out_xn;
  logic [5:0] in_y0, in_yn, eng_y0, eng_yn, eng_out_y0, eng_out_yn, out_y0, out_yn;
  logic [8:0] eng_size, eng_addr;
  logic [511:0] eng_flags;
  logic [15:0] frame_status;
  int tests = 0, fails = 0, cyc = 0, out_seen = 0, start_seen = 0, exp_out_total = 0;
  logic [25:0] exp_box [$];
  logic [15:0] exp_stat [$];
  logic [25:0] ram_model [512];

  bbox_merge_sched dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_x0(in_x0), .in_xn(in_xn), .in_y0(in_y0), .in_yn(in_yn),
    .in_frame_end(in_frame_end), .in_ready(in_ready),
    .eng_start(eng_start), .eng_size(eng_size), .eng_flags(eng_flags), .eng_addr(eng_addr),
    .eng_x0(eng_x0), .eng_xn(eng_xn), .eng_y0(eng_y0), .eng_yn(eng_yn),
    .eng_out_en(eng_out_en), .eng_out_x0(eng_out_x0), .eng_out_xn(eng_out_xn),
    .eng_out_y0(eng_out_y0), .eng_out_yn(eng_out_yn), .eng_complete(eng_complete),
    .out_valid(out_valid), .out_x0(out_x0), .out_xn(out_xn), .out_y0(out_y0), .out_yn(out_yn),
    .frame_done(frame_done), .frame_status(frame_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (eng_start) start_seen++;
    if (out_valid) begin
      out_seen++;
      if (exp_box.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected got box=%0h with no expected box", {out_x0, out_xn, out_y0, out_yn});
      end else check("out_box", {out_x0, out_xn, out_y0, out_yn}, exp_box.pop_front());
    end
    if (frame_done) begin
      if (exp_stat.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL done_unexpected got status=%0h with no expected frame", frame_status);
      end else check("frame_status", frame_status, exp_stat.pop_front());
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_start"}, eng_start, 0);
    check({tag, "_size"}, eng_size, 0);
    check({tag, "_flags"}, eng_flags, 0);
    check({tag, "_rd"}, {eng_x0, eng_xn, eng_y0, eng_yn}, 0);
    check({tag, "_out"}, {out_valid, out_x0, out_xn, out_y0, out_yn, frame_done}, 0);
    check({tag, "_status"}, frame_status, 0);
  endtask

  task automatic run_frame(input int n, input int k, input bit complete, input bit drop, input bit abort, input bit fix);
    int stored, c0, t, s0;
    bit fe_last, cw, ovf;
    logic [25:0] b;
    logic [511:0] fexp;
    stored = 0;
    fe_last = n > 0 && $urandom_range(0, 1) == 1;
    ovf = n > 512 || drop;
    s0 = start_seen;
    check("ready_idle", in_ready, 1);
    for (int i = 0; i < n; i++) begin
      b = (fix && i == 0) ? {7'd10, 7'd20, 6'd5, 6'd9} : 26'($urandom);
      {in_x0, in_xn, in_y0, in_yn} = b;
      in_valid = 1'b1;
      in_frame_end = fe_last && i == n - 1;
      if (stored < 512) begin
        ram_model[stored] = b;
        stored++;
      end
      tick();
      in_valid = 1'b0;
      in_frame_end = 1'b0;
      if (i < n - 1 && $urandom_range(0, 3) == 0) tick();
    end
    if (n == 0) begin
      exp_stat.push_back({3'b001, 4'b0, 9'd0});
      in_frame_end = 1'b1;
      tick();
      in_frame_end = 1'b0;
      check("empty_done_next", frame_done, 1);
      tick();
      check("empty_no_start", start_seen, s0);
      check("empty_drained", exp_stat.size(), 0);
      return;
    end
    if (!fe_last) begin
      in_frame_end = 1'b1;
      tick();
      in_frame_end = 1'b0;
    end
    check("start_pulse", eng_start, 1);
    check("ready_start", in_ready, 0);
    check("eng_size", eng_size, stored > 511 ? 511 : stored);
    fexp = '0;
    for (int i = 0; i < stored; i++) fexp[i] = 1'b1;
    check("eng_flags", eng_flags, fexp);
    c0 = cyc;
    tick();
    check("start_once", eng_start, 0);
    check("ready_merge", in_ready, 0);
    if (drop) begin
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    for (int r = 0; r < 2; r++) begin
      eng_addr = r == 0 ? 9'(stored - 1) : 9'($urandom_range(0, stored - 1));
      tick();
      check("rd_data", {eng_x0, eng_xn, eng_y0, eng_yn}, ram_model[eng_addr]);
      check("size_stable", eng_size, stored > 511 ? 511 : stored);
    end
    cw = complete && k > 0 && $urandom_range(0, 1) == 1;
    for (int j = 0; j < k; j++) begin
      b = 26'($urandom);
      {eng_out_x0, eng_out_xn, eng_out_y0, eng_out_yn} = b;
      eng_out_en = 1'b1;
      exp_box.push_back(b);
      exp_out_total++;
      eng_complete = cw && j == k - 1;
      if (eng_complete) exp_stat.push_back({ovf, 1'b0, 1'b0, 4'b0, 9'(k)});
      tick();
      eng_out_en = 1'b0;
      eng_complete = 1'b0;
      if (abort) begin
        reset = 1'b1;
        tick();
        check_idle("mid_reset");
        reset = 1'b0;
        check("abort_drained", exp_box.size(), 0);
        return;
      end
      if (j < k - 1 && $urandom_range(0, 2) == 0) tick();
    end
    if (complete) begin
      if (!cw) begin
        exp_stat.push_back({ovf, 1'b0, 1'b0, 4'b0, 9'(k)});
        eng_complete = 1'b1;
        tick();
        eng_complete = 1'b0;
      end
      check("done_after_complete", frame_done, 1);
    end else begin
      exp_stat.push_back({ovf, 1'b1, 1'b0, 4'b0, 9'(k)});
      t = 0;
      while (!frame_done && t < 50000) begin
        tick();
        t++;
      end
      check("wdog_timing", cyc - c0, WDOG + 1);
      b = 26'($urandom);
      {eng_out_x0, eng_out_xn, eng_out_y0, eng_out_yn} = b;
      eng_out_en = 1'b1;
      tick();
      tick();
      eng_out_en = 1'b0;
    end
    tick();
    check("out_count", out_seen, exp_out_total);
    check("out_drained", exp_box.size(), 0);
    check("stat_drained", exp_stat.size(), 0);
    check("flags_cleared", eng_flags, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    {in_valid, in_frame_end, eng_out_en, eng_complete} = '0;
    {in_x0, in_xn, in_y0, in_yn} = '0;
    {eng_out_x0, eng_out_xn, eng_out_y0, eng_out_yn} = '0;
    eng_addr = '0;
    reset = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    run_frame(1, 1, 1, 0, 0, 1);
    run_frame(3, 2, 1, 0, 0, 0);
    run_frame(0, 0, 1, 0, 0, 0);
    run_frame(520, 3, 1, 0, 0, 0);
    run_frame(4, 2, 0, 0, 0, 0);
    run_frame(3, 1, 1, 0, 1, 0);
    run_frame(2, 2, 1, 0, 0, 0);
    repeat (6) run_frame($urandom_range(1, 40), $urandom_range(0, 5), 1, $urandom_range(0, 1) == 1, 0, 0);
    repeat (2) tick();
    check("final_out_drained", exp_box.size(), 0);
    check("final_stat_drained", exp_stat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
